counter_updown_mod: RTL and testbench
=====================================

Name: counter_updown_mod

Overview:
Parametrised synchronous up/down modulo counter, the next generation of the team's 8-bit enable counter. It adds programmable width and modulus, direction control, parallel load, synchronous clear, and a wrap or saturate mode. It also provides terminal-count and sticky overflow status. It serves as a general timing and event-counting primitive for timers, dividers and sequence generators.

Parameters:
WIDTH, 8, bit width of count and load_val (2..32)
MAX_VAL, 255, highest count value (modulus-1); must satisfy 1 <= MAX_VAL <= 2^WIDTH-1
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count step enable
up_dn  input  1  1 = count up, 0 = count down; sampled only when counting
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
clear  input  1  synchronous clear to zero (not a reset; status flags unaffected)
ovf_clr  input  1  clears the sticky ovf flag
count  output  WIDTH  current count, registered
tc  output  1  one-cycle registered pulse on each wrap or limit hit
ovf  output  1  sticky: a wrap or saturation attempt has occurred since the last clear
at_max  output  1  combinational: count == MAX_VAL
at_zero  output  1  combinational: count == 0

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high. Every register updates only on the rising edge of clk.
- Reset values: count=0, tc=0, ovf=0. As a result, at_zero=1 and at_max=0 during and after reset.
- Priority per edge: reset > clear > load > enable. Lower-priority actions are ignored in that cycle.
- clear: count <= 0 and tc <= 0. ovf is unchanged.
- load: count <= min(load_val, MAX_VAL). A load_val above MAX_VAL is clamped to MAX_VAL, not truncated. tc <= 0.
- enable=1 with up_dn=1:
  - If count < MAX_VAL: count <= count+1.
  - If count == MAX_VAL and wrap mode: count <= 0, tc <= 1, ovf set.
  - If count == MAX_VAL and SATURATE=1: count holds, tc <= 1, ovf set.
- enable=1 with up_dn=0:
  - If count > 0: count <= count-1.
  - If count == 0 and wrap mode: count <= MAX_VAL, tc <= 1, ovf set.
  - If count == 0 and SATURATE=1: count holds, tc <= 1, ovf set.
- enable=0 with no clear or load: count holds and tc <= 0.
- tc is high for exactly the one cycle following the limit event. In saturate mode, holding enable at the limit produces tc every cycle.
- ovf:
  - Set by any limit event.
  - Cleared by ovf_clr.
  - If set and ovf_clr occur on the same edge, set wins (ovf=1).
  - Cleared by reset only otherwise; clear and load do not affect it.
- Latency: count, tc and ovf reflect the inputs one edge after sampling. at_max and at_zero follow count with no added delay.
- Arithmetic: the internal next-count computation uses WIDTH bits. MAX_VAL = 2^WIDTH-1 must wrap cleanly with no overflow into unused bits.
- Direction change mid-count takes effect on the same edge it is sampled. There is no dead cycle.
- Reset during counting or while tc=1: all outputs return to reset values on that edge.

Test Plan:
(WIDTH=8, MAX_VAL=9 unless stated)
1. Reset then count up: assert reset 1 cycle, then enable=1, up_dn=1 for 12 cycles -> count 0,1..9,0,1. tc high exactly one cycle after 9->0. ovf=1 from then on.
2. Count down with wrap: load load_val=2, then enable=1, up_dn=0 -> count 2,1,0,9,8. tc pulses once after 0->9.
3. Saturate mode (SATURATE=1): count up from 8 for 4 cycles -> count 9,9,9,9. tc=1 each cycle at the limit. Count down from 1 -> 0,0 and holds.
4. Priority and clamp: load=1 with load_val=200 -> count=9. Then clear=1, load=1 and enable=1 together -> count=0. Then reset=1 with clear=1 -> all outputs at reset values.
5. Sticky flag: trigger a wrap -> ovf=1. Then enable=0 for 5 cycles -> ovf stays 1. Pulse ovf_clr -> ovf=0. Then wrap on the same edge as ovf_clr -> ovf=1.
6. Full-range and enable gating (WIDTH=8, MAX_VAL=255): count up from 254 -> 255,0 with tc. Toggle enable low for 3 cycles mid-count -> count holds and tc=0.

Source files
------------

// File: rtl/counter_updown_mod.sv
// Parametrised synchronous up/down modulo counter with parallel load,
// synchronous clear, wrap or saturate behaviour at the limits, a one-cycle
// terminal-count pulse and a sticky overflow flag.
module counter_updown_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  // A load above the modulus is clamped to the top value rather than truncated.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  // One counting step in WIDTH-bit arithmetic; the limit cases never reach
  // the +1/-1 path, so MAX_VAL = 2^WIDTH-1 cannot spill into unused bits.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                  input logic up);
    if (up) begin
      if (c == MAX_C) return SATURATE ? c : '0;
      return c + ONE;
    end
    if (c == '0) return SATURATE ? c : MAX_C;
    return c - ONE;
  endfunction

  logic limit_event;

  assign at_max  = (count == MAX_C);
  assign at_zero = (count == '0);

  // A limit event is a counting step attempted at the boundary in the current direction.
  always_comb begin
    limit_event = enable && !clear && !load && (up_dn ? at_max : at_zero);
  end

  // Count register with reset > clear > load > enable priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= clamp_load(load_val);
    end else if (enable) begin
      count <= step_count(count, up_dn);
    end
  end

  // Terminal-count pulse: high only for the cycle after a limit event.
  always_ff @(posedge clk) begin
    if (reset) begin
      tc <= 1'b0;
    end else begin
      tc <= limit_event;
    end
  end

  // Sticky overflow: a new event beats a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (limit_event) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Testbench for counter_updown_mod: three instances (wrap mod 10, saturate
// mod 10, wrap mod 256) share one stimulus stream and are compared against
// an arithmetic reference model plus directed expected sequences.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       reset, enable, up_dn, load, clear, ovf_clr;
  logic [7:0] load_val;

  logic [7:0] cnt [3];
  logic       tcv [3];
  logic       ovfv [3];
  logic       amax [3];
  logic       azero [3];

  int checks = 0;
  int failures = 0;

  // reference model state
  int maxv [3] = '{9, 9, 255};
  bit sat  [3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt [3];
  bit m_tc  [3];
  bit m_ovf [3];

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .ovf_clr(ovf_clr),
    .count(cnt[0]), .tc(tcv[0]), .ovf(ovfv[0]), .at_max(amax[0]), .at_zero(azero[0]));

  counter_updown_mod #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .ovf_clr(ovf_clr),
    .count(cnt[1]), .tc(tcv[1]), .ovf(ovfv[1]), .at_max(amax[1]), .at_zero(azero[1]));

  counter_updown_mod #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u_full (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .ovf_clr(ovf_clr),
    .count(cnt[2]), .tc(tcv[2]), .ovf(ovfv[2]), .at_max(amax[2]), .at_zero(azero[2]));

  // Reference behaviour of one rising edge, written from the counting rules
  // with modular arithmetic.
  task automatic model_edge();
    bit ev;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
      end else begin
        ev = 1'b0;
        if (clear) m_cnt[i] = 0;
        else if (load) m_cnt[i] = (int'(load_val) > maxv[i]) ? maxv[i] : int'(load_val);
        else if (enable) begin
          if (up_dn) begin
            ev = (m_cnt[i] == maxv[i]);
            if (sat[i]) m_cnt[i] = (m_cnt[i] + 1 > maxv[i]) ? maxv[i] : m_cnt[i] + 1;
            else        m_cnt[i] = (m_cnt[i] + 1) % (maxv[i] + 1);
          end else begin
            ev = (m_cnt[i] == 0);
            if (sat[i]) m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            else        m_cnt[i] = (m_cnt[i] + maxv[i]) % (maxv[i] + 1);
          end
        end
        m_tc[i] = ev;
        if (ev) m_ovf[i] = 1'b1;
        else if (ovf_clr) m_ovf[i] = 1'b0;
      end
    end
  endtask

  // Advance one clock edge, update the model, and settle past the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b0; enable = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val = 8'd0; clear = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    enable = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 8'd0 || tcv[i] !== 1'b0 || ovfv[i] !== 1'b0 ||
          amax[i] !== 1'b0 || azero[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset inst%0d count=%0d tc=%b ovf=%b at_max=%b at_zero=%b required 0 0 0 0 1",
                 i, cnt[i], tcv[i], ovfv[i], amax[i], azero[i]);
      end
    end
    set_idle();
  endtask

  task automatic test_count_up();
    int exp_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    set_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    enable = 1'b1;
    up_dn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (cnt[0] !== 8'(exp_seq[k]) || tcv[0] !== (k == 9) || ovfv[0] !== (k >= 9)) begin
        failures++;
        $display("FAIL count_up step%0d count=%0d tc=%b ovf=%b required count=%0d tc=%0d ovf=%0d",
                 k, cnt[0], tcv[0], ovfv[0], exp_seq[k], (k == 9), (k >= 9));
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 8'(m_cnt[i]) || tcv[i] !== m_tc[i] || ovfv[i] !== m_ovf[i] ||
            amax[i] !== (m_cnt[i] == maxv[i]) || azero[i] !== (m_cnt[i] == 0)) begin
          failures++;
          $display("FAIL count_up_model inst%0d count=%0d tc=%b ovf=%b required count=%0d tc=%0d ovf=%0d",
                   i, cnt[i], tcv[i], ovfv[i], m_cnt[i], m_tc[i], m_ovf[i]);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_count_down();
    int exp_seq [5] = '{1, 0, 9, 8, 7};
    set_idle();
    load = 1'b1;
    load_val = 8'd2;
    step();
    checks++;
    if (cnt[0] !== 8'd2 || tcv[0] !== 1'b0) begin
      failures++;
      $display("FAIL down_load count=%0d tc=%b required count=2 tc=0", cnt[0], tcv[0]);
    end
    load = 1'b0;
    enable = 1'b1;
    up_dn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (cnt[0] !== 8'(exp_seq[k]) || tcv[0] !== (k == 2)) begin
        failures++;
        $display("FAIL count_down step%0d count=%0d tc=%b required count=%0d tc=%0d",
                 k, cnt[0], tcv[0], exp_seq[k], (k == 2));
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 8'(m_cnt[i]) || tcv[i] !== m_tc[i] || ovfv[i] !== m_ovf[i] ||
            amax[i] !== (m_cnt[i] == maxv[i]) || azero[i] !== (m_cnt[i] == 0)) begin
          failures++;
          $display("FAIL count_down_model inst%0d count=%0d tc=%b ovf=%b required count=%0d tc=%0d ovf=%0d",
                   i, cnt[i], tcv[i], ovfv[i], m_cnt[i], m_tc[i], m_ovf[i]);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_saturate();
    set_idle();
    load = 1'b1;
    load_val = 8'd8;
    step();
    load = 1'b0;
    enable = 1'b1;
    up_dn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (cnt[1] !== 8'd9 || tcv[1] !== (k >= 1) || amax[1] !== 1'b1) begin
        failures++;
        $display("FAIL sat_up step%0d count=%0d tc=%b at_max=%b required count=9 tc=%0d at_max=1",
                 k, cnt[1], tcv[1], amax[1], (k >= 1));
      end
    end
    enable = 1'b0;
    load = 1'b1;
    load_val = 8'd1;
    step();
    load = 1'b0;
    enable = 1'b1;
    up_dn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (cnt[1] !== 8'd0 || tcv[1] !== (k >= 1) || ovfv[1] !== 1'b1) begin
        failures++;
        $display("FAIL sat_down step%0d count=%0d tc=%b ovf=%b required count=0 tc=%0d ovf=1",
                 k, cnt[1], tcv[1], ovfv[1], (k >= 1));
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 8'(m_cnt[i]) || tcv[i] !== m_tc[i] || ovfv[i] !== m_ovf[i]) begin
          failures++;
          $display("FAIL sat_model inst%0d count=%0d tc=%b ovf=%b required count=%0d tc=%0d ovf=%0d",
                   i, cnt[i], tcv[i], ovfv[i], m_cnt[i], m_tc[i], m_ovf[i]);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_priority();
    set_idle();
    load = 1'b1;
    load_val = 8'd200;
    step();
    checks++;
    if (cnt[0] !== 8'd9 || cnt[1] !== 8'd9 || cnt[2] !== 8'd200) begin
      failures++;
      $display("FAIL clamp counts=%0d/%0d/%0d required 9/9/200", cnt[0], cnt[1], cnt[2]);
    end
    clear = 1'b1;
    enable = 1'b1;
    up_dn = 1'b1;
    step();
    checks++;
    if (cnt[0] !== 8'd0 || cnt[1] !== 8'd0 || cnt[2] !== 8'd0 || tcv[0] !== 1'b0) begin
      failures++;
      $display("FAIL clear_wins counts=%0d/%0d/%0d tc=%b required 0/0/0 tc=0",
               cnt[0], cnt[1], cnt[2], tcv[0]);
    end
    clear = 1'b0;
    load_val = 8'd5;
    step();
    checks++;
    if (cnt[0] !== 8'd5 || cnt[2] !== 8'd5) begin
      failures++;
      $display("FAIL load_wins counts=%0d/%0d required 5/5", cnt[0], cnt[2]);
    end
    load = 1'b0;
    reset = 1'b1;
    clear = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt[i] !== 8'd0 || tcv[i] !== 1'b0 || ovfv[i] !== 1'b0 ||
          amax[i] !== 1'b0 || azero[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_clear inst%0d count=%0d tc=%b ovf=%b at_max=%b at_zero=%b required 0 0 0 0 1",
                 i, cnt[i], tcv[i], ovfv[i], amax[i], azero[i]);
      end
    end
    set_idle();
  endtask

  task automatic test_sticky();
    set_idle();
    load = 1'b1;
    load_val = 8'd9;
    step();
    load = 1'b0;
    enable = 1'b1;
    up_dn = 1'b1;
    step();
    checks++;
    if (cnt[0] !== 8'd0 || tcv[0] !== 1'b1 || ovfv[0] !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set count=%0d tc=%b ovf=%b required 0 1 1", cnt[0], tcv[0], ovfv[0]);
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (ovfv[0] !== 1'b1 || tcv[0] !== 1'b0 || cnt[0] !== 8'd0) begin
        failures++;
        $display("FAIL sticky_hold step%0d count=%0d tc=%b ovf=%b required 0 0 1",
                 k, cnt[0], tcv[0], ovfv[0]);
      end
    end
    ovf_clr = 1'b1;
    step();
    checks++;
    if (ovfv[0] !== 1'b0 || ovfv[1] !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clr ovf=%b/%b required 0/0", ovfv[0], ovfv[1]);
    end
    ovf_clr = 1'b0;
    load = 1'b1;
    load_val = 8'd9;
    step();
    load = 1'b0;
    enable = 1'b1;
    ovf_clr = 1'b1;
    step();
    checks++;
    if (ovfv[0] !== 1'b1 || ovfv[1] !== 1'b1 || ovfv[2] !== 1'b0) begin
      failures++;
      $display("FAIL sticky_set_beats_clr ovf=%b/%b/%b required 1/1/0", ovfv[0], ovfv[1], ovfv[2]);
    end
    set_idle();
  endtask

  task automatic test_full_range();
    int exp_seq [9] = '{255, 0, 1, 2, 2, 2, 2, 3, 4};
    bit en_seq  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    set_idle();
    load = 1'b1;
    load_val = 8'd254;
    step();
    load = 1'b0;
    up_dn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      enable = en_seq[k];
      step();
      checks++;
      if (cnt[2] !== 8'(exp_seq[k]) || tcv[2] !== (k == 1) || amax[2] !== (k == 0)) begin
        failures++;
        $display("FAIL full_range step%0d count=%0d tc=%b at_max=%b required count=%0d tc=%0d at_max=%0d",
                 k, cnt[2], tcv[2], amax[2], exp_seq[k], (k == 1), (k == 0));
      end
    end
    set_idle();
  endtask

  task automatic test_random();
    set_idle();
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(0, 49) == 0);
      clear    = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 8'($urandom_range(0, 255));
      enable   = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 2) != 0);
      ovf_clr  = ($urandom_range(0, 9) == 0);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 8'(m_cnt[i]) || tcv[i] !== m_tc[i] || ovfv[i] !== m_ovf[i] ||
            amax[i] !== (m_cnt[i] == maxv[i]) || azero[i] !== (m_cnt[i] == 0)) begin
          failures++;
          $display("FAIL random cyc%0d inst%0d count=%0d tc=%b ovf=%b required count=%0d tc=%0d ovf=%0d",
                   k, i, cnt[i], tcv[i], ovfv[i], m_cnt[i], m_tc[i], m_ovf[i]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
    end
    set_idle();
    @(negedge clk);
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_priority();
    test_sticky();
    test_full_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
